// File: rtl/std_div_share_pkg.sv
// std_div_share_pkg: shared types and helpers for the shared divider slice.
// Optional feature macro used by this slice: DIV_SHARE_ZERO_FLAG_EN.
package std_div_share_pkg;

    // Sequencer states: idle/arbitrate, iterate, publish result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The divisor register holds the divisor pre-shifted by width-1 bits.
    function automatic int divisor_width(input int w);
        return 2 * w - 1;
    endfunction

endpackage

// File: rtl/std_div_share_if.sv
// std_div_share_if: requester-facing bus of the shared divider.
// Handshake: a requester raises go[i] with its operands on left/right and
// holds go[i] until done[i] pulses for one cycle; it drops go[i] the cycle
// after done. Dropping go[i] early while it is being served aborts the op.
// With DIV_SHARE_ZERO_FLAG_EN defined the bus also carries div_by_zero.
// dbg_state / dbg_rr_ptr expose the sequencer state for observation.
interface std_div_share_if #(
    parameter int width = 32,
    parameter int NREQ  = 4
);
    import std_div_share_pkg::*;

    localparam int IDXW = $clog2(NREQ);

    logic [NREQ-1:0]       go;
    logic [NREQ*width-1:0] left;
    logic [NREQ*width-1:0] right;
    logic [width-1:0]      out_quotient;
    logic [width-1:0]      out_remainder;
    logic [NREQ-1:0]       done;
    logic [IDXW-1:0]       grant;
    logic                  busy;
`ifdef DIV_SHARE_ZERO_FLAG_EN
    logic                  div_by_zero;
`endif
    state_t                dbg_state;
    logic [IDXW-1:0]       dbg_rr_ptr;

    modport master (
        output go, left, right,
        input  out_quotient, out_remainder, done, grant, busy,
`ifdef DIV_SHARE_ZERO_FLAG_EN
        input  div_by_zero,
`endif
        input  dbg_state, dbg_rr_ptr
    );

    modport slave (
        input  go, left, right,
        output out_quotient, out_remainder, done, grant, busy,
`ifdef DIV_SHARE_ZERO_FLAG_EN
        output div_by_zero,
`endif
        output dbg_state, dbg_rr_ptr
    );

endinterface

// File: rtl/std_div_share_iter.sv
// std_div_iter: iterative restoring unsigned divider datapath.
// start loads the operands; one quotient bit is resolved per cycle, MSB
// first. last is high once all width bits are resolved and the datapath
// then holds its result until the next start. No handshake logic here.
module std_div_iter
    import std_div_share_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             last
);

    localparam int DW = divisor_width(width);
    localparam int CW = $clog2(width + 1);

    logic [width-1:0] rem_q;
    logic [width-1:0] quo_q;
    logic [width-1:0] msk_q;
    logic [DW-1:0]    dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             fits;

    // Full-width unsigned compare: the shifted divisor may exceed width bits.
    assign fits = (dvs_q <= DW'(rem_q));
    assign last = (cnt_q == CW'(width));

    // Load on start, otherwise resolve one quotient bit per cycle until last.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rem_q <= '0;
            quo_q <= '0;
            msk_q <= '0;
            dvs_q <= '0;
            cnt_q <= CW'(width);
        end else if (start) begin
            rem_q <= dividend;
            quo_q <= '0;
            msk_q <= width'(1) << (width - 1);
            dvs_q <= DW'(divisor) << (width - 1);
            cnt_q <= '0;
        end else if (!last) begin
            if (fits) begin
                rem_q <= rem_q - dvs_q[width-1:0];
                quo_q <= quo_q | msk_q;
            end
            dvs_q <= dvs_q >> 1;
            msk_q <= msk_q >> 1;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/std_div_share.sv
// std_div_share: round-robin arbiter/sequencer sharing one restoring divider
// among NREQ go/done requesters. Results appear on shared registered buses
// with a one-cycle done pulse to the served requester.
// Optional macro DIV_SHARE_ZERO_FLAG_EN: adds div_by_zero and skips the
// iteration phase for a zero divisor (latency 2 instead of width+2).
module std_div_share
    import std_div_share_pkg::*;
#(
    parameter int width = 32,
    parameter int NREQ  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    std_div_share_if.slave    bus
);

    localparam int IDXW = $clog2(NREQ);

    state_t            state_q, state_n;
    logic [IDXW-1:0]   rr_ptr_q;
    logic [IDXW-1:0]   grant_q;
    logic [IDXW-1:0]   pick_idx;
    logic              pick_valid;
    logic              start;
    logic              go_held;
    logic [width-1:0]  sel_left;
    logic [width-1:0]  sel_right;
    logic [width-1:0]  quo_out_q;
    logic [width-1:0]  rem_out_q;
    logic [NREQ-1:0]   done_q;
    logic [width-1:0]  iter_quo;
    logic [width-1:0]  iter_rem;
    logic              iter_last;
`ifdef DIV_SHARE_ZERO_FLAG_EN
    logic              dz_q;
    logic              dz_out_q;
`endif

    // Round-robin pick: first asserted go at or after rr_ptr, wrapping.
    // Scanning distance from high to low lets the nearest requester win.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.go[i] && (((int'(rr_ptr_q) + k) % NREQ) == i)) begin
                    pick_valid = 1'b1;
                    pick_idx   = IDXW'(i);
                end
            end
        end
    end

    // Operand mux for the requester being picked this cycle.
    always_comb begin
        sel_left  = '0;
        sel_right = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDXW'(i) == pick_idx) begin
                sel_left  = bus.left[i*width +: width];
                sel_right = bus.right[i*width +: width];
            end
        end
    end

    assign start   = (state_q == IDLE) && pick_valid;
    assign go_held = |(bus.go & (NREQ'(1) << grant_q));

    std_div_iter #(.width(width)) u_iter (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dividend  (sel_left),
        .divisor   (sel_right),
        .quotient  (iter_quo),
        .remainder (iter_rem),
        .last      (iter_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic; losing go on the served requester aborts the op.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (!go_held) begin
                    state_n = IDLE;
`ifdef DIV_SHARE_ZERO_FLAG_EN
                end else if (dz_q) begin
                    state_n = DONE;
`endif
                end else if (iter_last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Grant latch, result publication, done pulse and round-robin advance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
`ifdef DIV_SHARE_ZERO_FLAG_EN
            dz_q      <= 1'b0;
            dz_out_q  <= 1'b0;
`endif
        end else begin
            done_q <= '0;
            if (start) begin
                grant_q <= pick_idx;
`ifdef DIV_SHARE_ZERO_FLAG_EN
                dz_q    <= (sel_right == '0);
`endif
            end
            if (state_q == DONE) begin
                done_q    <= NREQ'(1) << grant_q;
                rem_out_q <= iter_rem;
                rr_ptr_q  <= (grant_q == IDXW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
`ifdef DIV_SHARE_ZERO_FLAG_EN
                // Iteration was skipped, so force the natural all-ones result.
                quo_out_q <= dz_q ? '1 : iter_quo;
                dz_out_q  <= dz_q;
`else
                quo_out_q <= iter_quo;
`endif
            end
        end
    end

    assign bus.out_quotient  = quo_out_q;
    assign bus.out_remainder = rem_out_q;
    assign bus.done          = done_q;
    assign bus.grant         = grant_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.dbg_state     = state_q;
    assign bus.dbg_rr_ptr    = rr_ptr_q;
`ifdef DIV_SHARE_ZERO_FLAG_EN
    assign bus.div_by_zero   = dz_out_q;
`endif

endmodule

// File: tb/tb_std_div_share.sv
// tb_std_div_share: directed bench for std_div_share (width=8, NREQ=4).
// Expected results are queued when a request is issued; a monitor pops
// and compares on every done pulse, including the cycle it arrives in.
module tb_std_div_share;
    import std_div_share_pkg::*;

    localparam int W = 8;
    localparam int N = 4;
    localparam int EW = N + 2 * W;
`ifdef DIV_SHARE_ZERO_FLAG_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = W + 2;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [EW-1:0] mon_e;
    int            mon_c;

    std_div_share_if #(.width(W), .NREQ(N)) bus ();

    std_div_share #(.width(W), .NREQ(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock and cycle counter (cyc = number of rising edges so far).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_op(input logic [N-1:0] dmask, input logic [W-1:0] q,
                             input logic [W-1:0] r, input int at);
        exp_q.push_back({dmask, q, r});
        exp_cyc_q.push_back(at);
    endtask

    task automatic set_req(input int i, input logic [W-1:0] l, input logic [W-1:0] r);
        bus.left[i*W +: W]  = l;
        bus.right[i*W +: W] = r;
    endtask

    // Each requester drops its go in the cycle its done is seen.
    task automatic wait_go_clear(input int bound);
        bit finished;
        finished = 0;
        for (int t = 0; t < bound && !finished; t++) begin
            @(negedge clk);
            bus.go = bus.go & ~bus.done;
            if (bus.go == '0) finished = 1;
        end
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL wait_done_timeout: actual go=%b required=0000", bus.go);
        end
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_grant"}, 32'(bus.grant), 0);
        check({tag, "_quotient"}, 32'(bus.out_quotient), 0);
        check({tag, "_remainder"}, 32'(bus.out_remainder), 0);
        check({tag, "_state"}, 32'(bus.dbg_state), 32'(IDLE));
        check({tag, "_rr_ptr"}, 32'(bus.dbg_rr_ptr), 0);
`ifdef DIV_SHARE_ZERO_FLAG_EN
        check({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 0);
`endif
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.done !== '0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: actual done=%b required=none (cycle %0d)", bus.done, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("done_mask", 32'(bus.done), 32'(mon_e[EW-1:2*W]));
                check("quotient", 32'(bus.out_quotient), 32'(mon_e[2*W-1:W]));
                check("remainder", 32'(bus.out_remainder), 32'(mon_e[W-1:0]));
                check("done_cycle", 32'(cyc), 32'(mon_c));
            end
        end
    end

    initial begin
        int e;
        bus.go    = '0;
        bus.left  = '0;
        bus.right = '0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_state("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Single request: 100 / 7 = 14 r 2, done 10 cycles after sampling.
        set_req(0, 8'd100, 8'd7);
        bus.go = 4'b0001;
        expect_op(4'b0001, 8'd14, 8'd2, cyc + 1 + W + 2);
        @(negedge clk);
        check("t1_busy", 32'(bus.busy), 1);
        check("t1_grant", 32'(bus.grant), 0);
        check("t1_state", 32'(bus.dbg_state), 32'(RUN));
        wait_go_clear(40);
        check("t1_rr_ptr", 32'(bus.dbg_rr_ptr), 1);

        // Boundary: 255 / 1 on requester 3, moves rr_ptr back to 0.
        set_req(3, 8'd255, 8'd1);
        bus.go = 4'b1000;
        expect_op(4'b1000, 8'd255, 8'd0, cyc + 1 + W + 2);
        wait_go_clear(40);
        check("t2_rr_ptr", 32'(bus.dbg_rr_ptr), 0);

        // Contention: service order 0,1,3 with done pulses 11 cycles apart.
        set_req(0, 8'd50, 8'd6);
        set_req(1, 8'd200, 8'd13);
        set_req(3, 8'd77, 8'd10);
        bus.go = 4'b1011;
        e = cyc + 1;
        expect_op(4'b0001, 8'd8, 8'd2, e + 10);
        expect_op(4'b0010, 8'd15, 8'd5, e + 21);
        expect_op(4'b1000, 8'd7, 8'd7, e + 32);
        wait_go_clear(100);
        check("t3_rr_ptr", 32'(bus.dbg_rr_ptr), 0);

        // Abort: requester 1 drops go mid-RUN; no done, outputs unchanged.
        set_req(1, 8'd120, 8'd11);
        bus.go = 4'b0010;
        repeat (5) @(negedge clk);
        check("t4_busy_mid", 32'(bus.busy), 1);
        bus.go = 4'b0000;
        @(negedge clk);
        check("t4_state", 32'(bus.dbg_state), 32'(IDLE));
        check("t4_busy", 32'(bus.busy), 0);
        repeat (15) @(negedge clk);
        check("t4_quotient_hold", 32'(bus.out_quotient), 7);
        check("t4_remainder_hold", 32'(bus.out_remainder), 7);
        check("t4_rr_ptr", 32'(bus.dbg_rr_ptr), 0);

        // Follow-up request on requester 1: 90 / 9 = 10 r 0.
        set_req(1, 8'd90, 8'd9);
        bus.go = 4'b0010;
        expect_op(4'b0010, 8'd10, 8'd0, cyc + 1 + W + 2);
        wait_go_clear(40);
        check("t5_rr_ptr", 32'(bus.dbg_rr_ptr), 2);
`ifdef DIV_SHARE_ZERO_FLAG_EN
        check("t5_div_by_zero", 32'(bus.div_by_zero), 0);
`endif

        // Divide by zero: 45 / 0 gives all ones and remainder 45.
        set_req(2, 8'd45, 8'd0);
        bus.go = 4'b0100;
        expect_op(4'b0100, 8'd255, 8'd45, cyc + 1 + ZLAT);
        wait_go_clear(40);
        check("t6_rr_ptr", 32'(bus.dbg_rr_ptr), 3);
`ifdef DIV_SHARE_ZERO_FLAG_EN
        check("t6_div_by_zero", 32'(bus.div_by_zero), 1);
`endif

        // Boundary: 0 / 9 = 0 r 0, still full latency.
        set_req(3, 8'd0, 8'd9);
        bus.go = 4'b1000;
        expect_op(4'b1000, 8'd0, 8'd0, cyc + 1 + W + 2);
        wait_go_clear(40);
        check("t7_rr_ptr", 32'(bus.dbg_rr_ptr), 0);

        // Reset mid-RUN: op dropped, then the held go restarts from scratch.
        set_req(0, 8'd200, 8'd13);
        bus.go = 4'b0001;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_zero_state("midreset");
        reset_n = 1'b1;
        expect_op(4'b0001, 8'd15, 8'd5, cyc + 1 + W + 2);
        wait_go_clear(40);

        repeat (3) @(negedge clk);
        while (exp_q.size() != 0) begin
            total++;
            bad++;
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            $display("FAIL missing_done: actual=none required done=%b at cycle %0d",
                     mon_e[EW-1:2*W], mon_c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
